// File: rtl/mqsb_pkg.sv
// Shared definitions for the multi-queue shared packet buffer.
// Holds the width helpers and the default pointer and queue-id types.
package mqsb_pkg;

    function automatic int calc_qw(input int number_of_queues);
        return (number_of_queues > 1) ? $clog2(number_of_queues) : 1;
    endfunction

    function automatic int calc_aw(input int buffer_depth);
        return (buffer_depth > 1) ? $clog2(buffer_depth) : 1;
    endfunction

    localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
    localparam int DEFAULT_BUFFER_DEPTH     = 16;

    localparam int QW = calc_qw(DEFAULT_NUMBER_OF_QUEUES);
    localparam int AW = calc_aw(DEFAULT_BUFFER_DEPTH);

    typedef logic [AW-1:0] slot_ptr_t;
    typedef logic [QW-1:0] queue_id_t;

endpackage

// File: rtl/multi_queue_shared_buffer_ptr_fifo.sv
// Register-based FIFO of slot pointers with a combinational head and an occupancy count.
// Used for every logical queue and for the pool of recycled slots.
module ptr_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Out-of-range requests are dropped so the count can never wrap.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/multi_queue_shared_buffer.sv
// N logical FIFOs sharing one packet RAM; slots come from a fresh counter and a recycled pool.
// Enqueue uses valid/ready, dequeue returns data one cycle after an accepted request.
module multi_queue_shared_buffer
    import mqsb_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32,
    parameter int DATA_SIZE        = 678,
    parameter int BUFFER_DEPTH     = 16,
    parameter int QUEUE_DEPTH      = 16,
    localparam int QUEUE_W = calc_qw(NUMBER_OF_QUEUES),
    localparam int ADDR_W  = calc_aw(BUFFER_DEPTH)
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           enq_valid,
    input  logic [QUEUE_W-1:0]                             enq_queue,
    input  logic [DATA_SIZE-1:0]                           enq_data,
    output logic                                           enq_ready,
    input  logic                                           deq_req,
    input  logic [QUEUE_W-1:0]                             deq_queue,
    output logic                                           out_valid,
    output logic [DATA_SIZE-1:0]                           out_data,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] threshold,
    output logic [NUMBER_OF_QUEUES-1:0]                    empty,
    output logic [NUMBER_OF_QUEUES-1:0]                    full,
    output logic [NUMBER_OF_QUEUES-1:0]                    last_elem,
    output logic [NUMBER_OF_QUEUES-1:0]                    kill,
    output logic [ADDR_W:0]                                free_count
);

    localparam int OCC_W  = ADDR_W + 1;
    localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [OCC_W-1:0] DEPTH_COUNT = OCC_W'(BUFFER_DEPTH);
    localparam logic [OCC_W-1:0] QUEUE_FULL  = OCC_W'(QUEUE_DEPTH);
    localparam logic [OCC_W-1:0] ONE_ENTRY   = OCC_W'(1);

    logic [OCC_W-1:0]     fresh_cnt;
    logic [OCC_W-1:0]     rec_count;
    logic [ADDR_W-1:0]    rec_head;
    logic                 rec_push;
    logic                 rec_pop;
    logic                 freed_pending;
    logic [ADDR_W-1:0]    freed_slot;

    logic                 use_fresh;
    logic                 use_recycled;
    logic [ADDR_W-1:0]    alloc_slot;
    logic [ADDR_W-1:0]    deq_slot;
    logic                 enq_target_ok;
    logic                 deq_target_ok;
    logic                 enq_fire;
    logic                 deq_fire;

    logic [ADDR_W-1:0]    q_head [NUMBER_OF_QUEUES];
    logic [OCC_W-1:0]     occ    [NUMBER_OF_QUEUES];
    logic [DATA_SIZE-1:0] ram    [BUFFER_DEPTH];

    assign enq_target_ok = int'(enq_queue) < NUMBER_OF_QUEUES;
    assign deq_target_ok = int'(deq_queue) < NUMBER_OF_QUEUES;

    // A slot that was dequeued last cycle is still counted as free while it travels to the pool.
    assign free_count = (DEPTH_COUNT - fresh_cnt) + rec_count + OCC_W'(freed_pending);
    assign enq_ready  = enq_target_ok && (free_count != '0) && !full[enq_queue];
    assign enq_fire   = enq_valid && enq_ready;
    assign deq_fire   = deq_req && deq_target_ok && !empty[deq_queue];
    assign deq_slot   = q_head[deq_queue];

    // Fresh slots first, then the recycled pool, and finally the slot landing from last cycle's dequeue.
    assign use_fresh    = fresh_cnt < DEPTH_COUNT;
    assign use_recycled = !use_fresh && (rec_count != '0);
    assign alloc_slot   = use_fresh    ? fresh_cnt[ADDR_W-1:0] :
                          use_recycled ? rec_head : freed_slot;
    assign rec_pop      = enq_fire && use_recycled;
    assign rec_push     = freed_pending && !(enq_fire && !use_fresh && !use_recycled);

    ptr_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (BUFFER_DEPTH)
    ) u_recycled (
        .clock     (clock),
        .reset     (reset),
        .push      (rec_push),
        .push_data (freed_slot),
        .pop       (rec_pop),
        .head      (rec_head),
        .count     (rec_count)
    );

    for (genvar gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_queue
        logic [QCNT_W-1:0] cnt;
        logic              push;
        logic              pop;

        assign push = enq_fire && (int'(enq_queue) == gi);
        assign pop  = deq_fire && (int'(deq_queue) == gi);

        ptr_fifo #(
            .WIDTH (ADDR_W),
            .DEPTH (QUEUE_DEPTH)
        ) u_queue (
            .clock     (clock),
            .reset     (reset),
            .push      (push),
            .push_data (alloc_slot),
            .pop       (pop),
            .head      (q_head[gi]),
            .count     (cnt)
        );

        assign occ[gi] = OCC_W'(cnt);
    end

    always_comb begin
        empty     = '0;
        full      = '0;
        last_elem = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            empty[i]     = occ[i] == '0;
            full[i]      = occ[i] == QUEUE_FULL;
            last_elem[i] = occ[i] == ONE_ENTRY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fresh_cnt     <= '0;
            freed_pending <= 1'b0;
            freed_slot    <= '0;
            out_valid     <= 1'b0;
        end else begin
            if (enq_fire && use_fresh) begin
                fresh_cnt <= fresh_cnt + 1'b1;
            end
            freed_pending <= deq_fire;
            if (deq_fire) begin
                freed_slot <= deq_slot;
            end
            out_valid <= deq_fire;
        end
    end

    // The freed slot only re-enters circulation next edge, so this read never races a rewrite.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            ram[alloc_slot] <= enq_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data <= '0;
        end else if (deq_fire) begin
            out_data <= ram[deq_slot];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            kill <= '0;
        end else begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                kill[i] <= (threshold[i] != '0) && (REGISTER_SIZE'(occ[i]) > threshold[i]);
            end
        end
    end

endmodule

// File: tb/tb_multi_queue_shared_buffer.sv
// Self-checking bench for multi_queue_shared_buffer against a queue-of-packets reference model.
// Each scenario task drives stimulus and compares DUT outputs inline.
module tb_multi_queue_shared_buffer;
    import mqsb_pkg::*;

    localparam int NQ = 4;
    localparam int RS = 32;
    localparam int DW = 678;
    localparam int BD = 16;
    localparam int QD = 16;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  enq_valid;
    queue_id_t             enq_queue;
    logic [DW-1:0]         enq_data;
    logic                  enq_ready;
    logic                  deq_req;
    queue_id_t             deq_queue;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic [NQ-1:0][RS-1:0] threshold;
    logic [NQ-1:0]         empty;
    logic [NQ-1:0]         full;
    logic [NQ-1:0]         last_elem;
    logic [NQ-1:0]         kill;
    logic [4:0]            free_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NQ][$];
    logic          obs_ready, exp_ready, obs_valid, exp_valid;
    logic [DW-1:0] obs_data, exp_data;

    always #5 clock = ~clock;

    multi_queue_shared_buffer #(
        .NUMBER_OF_QUEUES (NQ),
        .REGISTER_SIZE    (RS),
        .DATA_SIZE        (DW),
        .BUFFER_DEPTH     (BD),
        .QUEUE_DEPTH      (QD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enq_valid  (enq_valid),
        .enq_queue  (enq_queue),
        .enq_data   (enq_data),
        .enq_ready  (enq_ready),
        .deq_req    (deq_req),
        .deq_queue  (deq_queue),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .threshold  (threshold),
        .empty      (empty),
        .full       (full),
        .last_elem  (last_elem),
        .kill       (kill),
        .free_count (free_count)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [703:0] t;
        for (int k = 0; k < 22; k++) t[k*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    function automatic int model_total();
        int t = 0;
        for (int q = 0; q < NQ; q++) t += mq[q].size();
        return t;
    endfunction

    function automatic logic [NQ-1:0] model_empty();
        logic [NQ-1:0] e;
        for (int q = 0; q < NQ; q++) e[q] = (mq[q].size() == 0);
        return e;
    endfunction

    function automatic logic [4:0] model_free();
        return 5'(BD - model_total());
    endfunction

    task automatic model_clear();
        for (int q = 0; q < NQ; q++) mq[q].delete();
        exp_data = '0;
    endtask

    // One clock of stimulus; the model decides acceptance from the rules on the pre-edge state.
    task automatic do_cycle(input logic ev, input logic [1:0] eq, input logic [DW-1:0] ed,
                            input logic dr, input logic [1:0] dq);
        logic acc_e, acc_d;
        enq_valid = ev; enq_queue = eq; enq_data = ed;
        deq_req = dr; deq_queue = dq;
        #1;
        exp_ready = (model_total() < BD) && (mq[eq].size() < QD);
        obs_ready = enq_ready;
        acc_e = ev && exp_ready;
        acc_d = dr && (mq[dq].size() != 0);
        @(posedge clock); #1;
        if (acc_d) exp_data = mq[dq].pop_front();
        if (acc_e) mq[eq].push_back(ed);
        exp_valid = acc_d;
        obs_valid = out_valid;
        obs_data  = out_data;
        enq_valid = 1'b0;
        deq_req   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; enq_valid = 1'b0; deq_req = 1'b0;
        enq_queue = '0; deq_queue = '0; enq_data = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (empty !== 4'hF) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1111", empty); end
        checks++; if (full !== 4'h0 || last_elem !== 4'h0) begin errors++; $display("[TB] FAIL reset_full_last: got %b/%b expected 0000/0000", full, last_elem); end
        checks++; if (kill !== 4'h0) begin errors++; $display("[TB] FAIL reset_kill: got %b expected 0000", kill); end
        checks++; if (free_count !== 5'd16) begin errors++; $display("[TB] FAIL reset_free_count: got %0d expected 16", free_count); end
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_enq_ready: got %0b expected 1", enq_ready); end
    endtask

    task automatic test_fifo_order();
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 2'd0, rand_data(), 1'b0, 2'd0);
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL order_enq_ready: got %0b expected %0b", obs_ready, exp_ready); end
        end
        checks++; if (free_count !== 5'd13) begin errors++; $display("[TB] FAIL order_free_13: got %0d expected 13", free_count); end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 2'd0, '0, 1'b1, 2'd0);
            checks++; if (obs_valid !== 1'b1) begin errors++; $display("[TB] FAIL order_out_valid: got %0b expected 1", obs_valid); end
            checks++; if (obs_data !== exp_data) begin errors++; $display("[TB] FAIL order_data: got %h expected %h", obs_data, exp_data); end
        end
        do_cycle(1'b0, 2'd0, '0, 1'b0, 2'd0);
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL order_pulse: got %0b expected 0", obs_valid); end
        checks++; if (obs_data !== exp_data) begin errors++; $display("[TB] FAIL order_hold: got %h expected %h", obs_data, exp_data); end
        checks++; if (free_count !== 5'd16) begin errors++; $display("[TB] FAIL order_free_16: got %0d expected 16", free_count); end
    endtask

    task automatic test_full_queue();
        for (int i = 0; i < QD; i++) begin
            do_cycle(1'b1, 2'd1, rand_data(), 1'b0, 2'd0);
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL full_fill_ready: got %0b expected %0b", obs_ready, exp_ready); end
        end
        checks++; if (full[1] !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: got %0b expected 1", full[1]); end
        checks++; if (free_count !== model_free()) begin errors++; $display("[TB] FAIL full_free: got %0d expected %0d", free_count, model_free()); end
        do_cycle(1'b1, 2'd0, rand_data(), 1'b0, 2'd0);
        checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL full_pool_empty_ready: got %0b expected %0b", obs_ready, exp_ready); end
        // Pool exhausted: the same-cycle enqueue must not borrow the slot being freed.
        do_cycle(1'b1, 2'd1, rand_data(), 1'b1, 2'd1);
        checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL full_no_bypass: got %0b expected %0b", obs_ready, exp_ready); end
        checks++; if (obs_valid !== 1'b1 || obs_data !== exp_data) begin errors++; $display("[TB] FAIL full_deq_data: got %0b/%h expected 1/%h", obs_valid, obs_data, exp_data); end
        checks++; if (full[1] !== 1'b0) begin errors++; $display("[TB] FAIL full_cleared: got %0b expected 0", full[1]); end
        do_cycle(1'b1, 2'd1, rand_data(), 1'b0, 2'd0);
        checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL full_ready_return: got %0b expected %0b", obs_ready, exp_ready); end
        while (mq[1].size() != 0) begin
            do_cycle(1'b0, 2'd0, '0, 1'b1, 2'd1);
            checks++; if (obs_valid !== exp_valid || obs_data !== exp_data) begin errors++; $display("[TB] FAIL full_drain: got %0b/%h expected %0b/%h", obs_valid, obs_data, exp_valid, exp_data); end
        end
        checks++; if (free_count !== 5'd16) begin errors++; $display("[TB] FAIL full_free_restore: got %0d expected 16", free_count); end
    endtask

    task automatic test_random_interleave();
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [1:0] eq, dq;
            r  = int'($urandom_range(0, 3));
            eq = 2'($urandom_range(0, 3));
            dq = 2'($urandom_range(0, 3));
            do_cycle(r != 1, eq, rand_data(), r != 0, dq);
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_ready op %0d: got %0b expected %0b", i, obs_ready, exp_ready); end
            checks++; if (obs_valid !== exp_valid || obs_data !== exp_data) begin errors++; $display("[TB] FAIL rand_out op %0d: got %0b/%h expected %0b/%h", i, obs_valid, obs_data, exp_valid, exp_data); end
            checks++; if (empty !== model_empty() || free_count !== model_free()) begin errors++; $display("[TB] FAIL rand_status op %0d: got %b/%0d expected %b/%0d", i, empty, free_count, model_empty(), model_free()); end
        end
        for (int q = 0; q < NQ; q++) begin
            while (mq[q].size() != 0) begin
                do_cycle(1'b0, 2'd0, '0, 1'b1, 2'(q));
                checks++; if (obs_valid !== 1'b1 || obs_data !== exp_data) begin errors++; $display("[TB] FAIL rand_drain q%0d: got %0b/%h expected 1/%h", q, obs_valid, obs_data, exp_data); end
            end
        end
    endtask

    task automatic test_kill();
        threshold[2] = 32'd3;
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 2'd2, rand_data(), 1'b0, 2'd0);
        repeat (2) do_cycle(1'b0, 2'd0, '0, 1'b0, 2'd0);
        checks++; if (kill !== 4'b0000) begin errors++; $display("[TB] FAIL kill_at_threshold: got %b expected 0000", kill); end
        do_cycle(1'b1, 2'd2, rand_data(), 1'b0, 2'd0);
        repeat (2) do_cycle(1'b0, 2'd0, '0, 1'b0, 2'd0);
        checks++; if (kill !== 4'b0100) begin errors++; $display("[TB] FAIL kill_above: got %b expected 0100", kill); end
        threshold[2] = '0;
        repeat (2) do_cycle(1'b0, 2'd0, '0, 1'b0, 2'd0);
        checks++; if (kill !== 4'b0000) begin errors++; $display("[TB] FAIL kill_disabled: got %b expected 0000", kill); end
        while (mq[2].size() != 0) begin
            do_cycle(1'b0, 2'd0, '0, 1'b1, 2'd2);
            checks++; if (obs_valid !== 1'b1 || obs_data !== exp_data) begin errors++; $display("[TB] FAIL kill_drain: got %0b/%h expected 1/%h", obs_valid, obs_data, exp_data); end
        end
    endtask

    task automatic test_back_to_back();
        do_cycle(1'b1, 2'd0, rand_data(), 1'b0, 2'd0);
        do_cycle(1'b1, 2'd0, rand_data(), 1'b1, 2'd0);
        checks++; if (obs_valid !== 1'b1 || obs_data !== exp_data) begin errors++; $display("[TB] FAIL b2b_same_queue_out: got %0b/%h expected 1/%h", obs_valid, obs_data, exp_data); end
        checks++; if (last_elem[0] !== 1'b1 || empty[0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_occ_one: got last=%0b empty=%0b expected last=1 empty=0", last_elem[0], empty[0]); end
        do_cycle(1'b1, 2'd3, rand_data(), 1'b1, 2'd3);
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty_deq_valid: got %0b expected 0", obs_valid); end
        checks++; if (last_elem[3] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_q3_enq: got %0b expected 1", last_elem[3]); end
        for (int q = 0; q < NQ; q++) begin
            while (mq[q].size() != 0) begin
                do_cycle(1'b0, 2'd0, '0, 1'b1, 2'(q));
                checks++; if (obs_valid !== 1'b1 || obs_data !== exp_data) begin errors++; $display("[TB] FAIL b2b_drain q%0d: got %0b/%h expected 1/%h", q, obs_valid, obs_data, exp_data); end
            end
        end
    endtask

    task automatic test_reset_in_flight();
        do_cycle(1'b1, 2'd1, rand_data(), 1'b0, 2'd0);
        do_cycle(1'b1, 2'd1, rand_data(), 1'b0, 2'd0);
        deq_req = 1'b1; deq_queue = 2'd1;
        @(posedge clock); #1;
        deq_req = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_flight_valid: got %0b expected 0", out_valid); end
        checks++; if (free_count !== 5'd16) begin errors++; $display("[TB] FAIL rst_flight_free: got %0d expected 16", free_count); end
        checks++; if (empty !== 4'hF) begin errors++; $display("[TB] FAIL rst_flight_empty: got %b expected 1111", empty); end
        do_cycle(1'b1, 2'd2, rand_data(), 1'b0, 2'd0);
        deq_req = 1'b1; deq_queue = 2'd2; reset = 1'b1;
        @(posedge clock); #1;
        deq_req = 1'b0; reset = 1'b0;
        model_clear();
        checks++; if (out_valid !== 1'b0 || empty !== 4'hF) begin errors++; $display("[TB] FAIL rst_same_cycle: got %0b/%b expected 0/1111", out_valid, empty); end
        do_cycle(1'b1, 2'd3, rand_data(), 1'b0, 2'd0);
        do_cycle(1'b0, 2'd0, '0, 1'b1, 2'd3);
        checks++; if (obs_valid !== 1'b1 || obs_data !== exp_data) begin errors++; $display("[TB] FAIL rst_recover: got %0b/%h expected 1/%h", obs_valid, obs_data, exp_data); end
    endtask

    initial begin
        threshold = '0;
        test_reset();
        test_fifo_order();
        test_full_queue();
        test_random_interleave();
        test_kill();
        test_back_to_back();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
